// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    PORT_IF,
    PORT_DM
  } arb_port_e;

  // Wide enough for MEM_LATENCY-1 with MEM_LATENCY up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester always wins, and on
// contention the requester that was not granted last time wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant; "last" names the index that won the previous contention slot.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the
// load/store path. One transaction is in flight at a time:
// grant -> wait for memory latency -> capture -> respond.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [AWIDTH-1:0] dm_addr_i,
  input  logic [DWIDTH-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DWIDTH-1:0] dm_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic              busy_o
);

  // The counter reload value: the last wait cycle is the one with cnt == 0.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  arb_state_e        state;
  arb_port_e         owner;
  arb_port_e         last_gnt;
  logic [CNT_W-1:0]  cnt;
  logic              is_write;
  logic              drop;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] data_q;
  logic [DWIDTH-1:0] if_rdata_q;
  logic [DWIDTH-1:0] dm_rdata_q;

  logic [1:0] pick;
  logic       slot;
  logic       grant_if;
  logic       grant_dm;
  logic       grant;
  logic       resp;
  logic       store;
  logic       flush_hit;

  // Arbitration is only open when no transaction is pending or the current
  // one is in its response cycle; reset closes it so no strobe leaks out.
  assign slot = rst && ((state == ARB_IDLE) || (state == ARB_RESP));
  assign resp = rst && (state == ARB_RESP);

  rr_pick2 u_pick (
    .req  ({dm_req_i, if_req_i}),
    .last (last_gnt == PORT_DM),
    .gnt  (pick)
  );

  assign grant_if = slot && pick[0];
  assign grant_dm = slot && pick[1];
  assign grant    = grant_if || grant_dm;
  assign store    = grant_dm && dm_we_i;

  // A flush only concerns a fetch that is already in flight.
  assign flush_hit = if_flush_i && (owner == PORT_IF) && (state != ARB_IDLE);

  assign if_gnt_o       = grant_if;
  assign dm_gnt_o       = grant_dm;
  assign mem_read_en_o  = grant_if || (grant_dm && !dm_we_i);
  assign mem_write_en_o = store;
  assign mem_addr_o     = grant_dm ? dm_addr_i : (grant_if ? if_addr_i : addr_q);
  assign mem_data_o     = store ? dm_wdata_i : data_q;

  assign if_rvalid_o = resp && (owner == PORT_IF) && !drop && !if_flush_i;
  assign dm_rvalid_o = resp && (owner == PORT_DM);
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign busy_o      = (state != ARB_IDLE);

  // Transaction FSM: grant bookkeeping, latency countdown, data capture and drop tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      cnt        <= '0;
      owner      <= PORT_IF;
      last_gnt   <= PORT_IF;
      is_write   <= 1'b0;
      drop       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (flush_hit) begin
        drop <= 1'b1;
      end
      if (grant) begin
        state    <= ARB_WAIT;
        cnt      <= CNT_INIT;
        owner    <= grant_dm ? PORT_DM : PORT_IF;
        last_gnt <= grant_dm ? PORT_DM : PORT_IF;
        is_write <= store;
        drop     <= 1'b0;
        addr_q   <= mem_addr_o;
        if (store) begin
          data_q <= dm_wdata_i;
        end
      end else begin
        case (state)
          ARB_WAIT: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              state <= ARB_RESP;
              if (!is_write) begin
                if (owner == PORT_DM) begin
                  dm_rdata_q <= mem_data_i;
                end else if (!drop && !if_flush_i) begin
                  if_rdata_q <= mem_data_i;
                end
              end
            end
          end
          ARB_RESP: state <= ARB_IDLE;
          default:  state <= ARB_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported memory between instruction fetch (IF) and the load/store path (DM).
- Sequences every access through a small FSM: grant, wait for the memory latency, capture the data, return the response.
- Sits between fetch/execute and the memory instance in the top level, and replaces the direct PC-vs-ALU address mux.
- busy_o feeds pipeline stall logic.

Parameters:
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- MEM_LATENCY, 1, cycles from memory request to valid mem_data_i; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- if_req_i  in  1  fetch read request; held until if_gnt_o
- if_addr_i  in  AWIDTH  fetch address; stable while if_req_i is high
- if_flush_i  in  1  discard any outstanding fetch response
- if_gnt_o  out  1  one-cycle grant pulse
- if_rvalid_o  out  1  one-cycle response pulse
- if_rdata_o  out  DWIDTH  fetch read data
- dm_req_i  in  1  data request; held until dm_gnt_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  AWIDTH  data address
- dm_wdata_i  in  DWIDTH  store data
- dm_gnt_o  out  1  one-cycle grant pulse
- dm_rvalid_o  out  1  load data valid, or store acknowledge
- dm_rdata_o  out  DWIDTH  load data
- mem_addr_o  out  AWIDTH  memory address
- mem_data_o  out  DWIDTH  memory write data
- mem_read_en_o  out  1  memory read strobe
- mem_write_en_o  out  1  memory write strobe
- mem_data_i  in  DWIDTH  memory read data
- busy_o  out  1  state != ARB_IDLE

Behaviour:
- FSM states: ARB_IDLE, ARB_WAIT, ARB_RESP.
- Arbitration runs only in ARB_IDLE and ARB_RESP.
  - Single requester: that requester wins.
  - Both requesting: the side opposite last_gnt wins (round-robin).
  - last_gnt resets to IF, so DM wins the first contention.
- Grant cycle T:
  - Winner's gnt_o = 1.
  - mem_addr_o = winner addr, combinational.
  - Read: mem_read_en_o = 1. Store: mem_write_en_o = 1 and mem_data_o = dm_wdata_i.
  - Registers updated: owner, is_write, last_gnt. cnt loads MEM_LATENCY-1. Next state = ARB_WAIT.
- Non-grant cycles:
  - mem_read_en_o = mem_write_en_o = 0.
  - mem_addr_o and mem_data_o hold the last granted values (registered copies).
- ARB_WAIT:
  - If cnt != 0: decrement cnt.
  - If cnt == 0 (cycle T+MEM_LATENCY): capture mem_data_i into the owner's rdata register (stores capture nothing) and go to ARB_RESP.
- ARB_RESP (cycle T+MEM_LATENCY+1):
  - Owner's rvalid_o = 1.
  - A new grant may issue in the same cycle (go to ARB_WAIT); otherwise go to ARB_IDLE.
- Latency and throughput:
  - Read latency from grant to rvalid = MEM_LATENCY+1.
  - Sustained throughput = one access per MEM_LATENCY+1 cycles.
- rdata outputs hold their value until the next capture for that port.
- Store ack: dm_rvalid_o pulses; dm_rdata_o is unchanged.
- Flush: if_flush_i high while owner==IF in ARB_WAIT or ARB_RESP:
  - Suppresses if_rvalid_o for that transaction (a sticky drop flag covers the whole transaction).
  - The memory read still completes; if_rdata_o is not updated.
  - Flush has no effect on DM transactions.
  - if_flush_i in the same cycle as if_req_i is ignored for grant purposes; IF must deassert req itself.
- Request deasserted before grant: no access is made. Requests after grant are not sampled until the next arbitration slot.
- At most one outstanding transaction; no queueing.
- Reset (rst == 0), including mid-transaction:
  - Next edge: state = ARB_IDLE, cnt = 0, owner = IF, last_gnt = IF, drop flag = 0.
  - All gnt, rvalid and mem enables = 0; rdata regs = 0; mem_addr_o = 0; mem_data_o = 0.
  - Outstanding response is lost, never signalled.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_e {ARB_IDLE, ARB_WAIT, ARB_RESP}
  - arb_port_e {PORT_IF, PORT_DM}
  - localparam CNT_W = 4
- Sub-module rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt[1:0] one-hot.
  - Reusable for future bus masters.

Test Plan:
- Reset then idle, MEM_LATENCY=1, rst low 2 cycles -> all outputs 0, busy_o=0; no enables while rst low.
- IF-only read, addr 0x0100_0000, memory returns 0x0000_0013 at T+1 -> if_gnt_o at T, mem_read_en_o at T, if_rvalid_o at T+2 with rdata 0x13, busy_o high T+1..T+2.
- Contention: if_req and dm_req (load 0x0100_0040) both high from T, held until granted -> DM granted T, IF granted T+2 in ARB_RESP; DM rvalid T+2, IF rvalid T+4, no gaps.
- Store, MEM_LATENCY=3: dm_we=1, addr 0x0100_0080, wdata 0xDEADBEEF -> mem_write_en_o=1 and mem_data_o=0xDEADBEEF at T only; dm_rvalid_o at T+4; dm_rdata_o unchanged.
- Flush: IF read granted T, if_flush_i pulse at T+1 -> no if_rvalid_o at T+2, if_rdata_o unchanged; next IF request granted at T+2.
- Reset mid-op: DM load granted T, rst low at T+1 -> ARB_IDLE at T+2, dm_rvalid_o never asserts, last_gnt=IF (DM wins next contention).
